sclib_tmr_hs_sender: RTL and testbench

- Source-side (initiator) end of a 4-phase level handshake used to pass single-cycle events from the local CLK domain to an asynchronous remote domain.
- The remote end observes REQ_OUT through its own synchronizer and returns ACK_IN.
- All state flops (FSM, REQ register, timeout counter, ACK synchronizer) are triplicated and majority-voted. Each copy reloads from the voted next value every cycle, so a single upset self-scrubs in one cycle.
- Sits next to the slave/master signal synchronizers in the bus controller, on outgoing strobe/event paths.

---
 rtl/sclib_tmr_syncff.sv | 39 +++
 rtl/sclib_tmr_hs_sender.sv | 153 +++++++++++++++
 tb/tb_sclib_tmr_hs_sender.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sclib_tmr_syncff.sv
// Triple-modular-redundant multi-flop synchronizer for one asynchronous level.
// Every stage of every copy reloads from the voted previous stage, so an upset self-scrubs.
module sclib_tmr_syncff #(
    parameter int SYNCC    = 2,
    parameter int SET1RST0 = 0
) (
    input  logic CLK,
    input  logic SRB,
    input  logic D,
    output logic Q
);

    localparam logic RST_VAL = 1'(SET1RST0 != 0);

    (* dont_touch = "true" *) logic [SYNCC-1:0] ch_q0;
    (* dont_touch = "true" *) logic [SYNCC-1:0] ch_q1;
    (* dont_touch = "true" *) logic [SYNCC-1:0] ch_q2;
    logic [SYNCC-1:0] ch_v;
    logic [SYNCC-1:0] ch_nx;

    assign ch_v  = (ch_q0 & ch_q1) | (ch_q0 & ch_q2) | (ch_q1 & ch_q2);
    // First stage of each copy samples the raw input on its own flop.
    assign ch_nx = {ch_v[SYNCC-2:0], D};

    always_ff @(posedge CLK or negedge SRB) begin
        if (!SRB) begin
            ch_q0 <= {SYNCC{RST_VAL}};
            ch_q1 <= {SYNCC{RST_VAL}};
            ch_q2 <= {SYNCC{RST_VAL}};
        end else begin
            ch_q0 <= ch_nx;
            ch_q1 <= ch_nx;
            ch_q2 <= ch_nx;
        end
    end

    assign Q = ch_v[SYNCC-1];

endmodule

// File: rtl/sclib_tmr_hs_sender.sv
// Initiator side of a 4-phase REQ/ACK level handshake with per-phase timeout.
// All state is triplicated; next state is computed from the 2-of-3 vote and written to every copy.
module sclib_tmr_hs_sender #(
    parameter int SYNCC   = 2,
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic CLK,
    input  logic SRB,
    input  logic PULSE_IN,
    input  logic ACK_IN,
    output logic REQ_OUT,
    output logic BUSY,
    output logic DONE,
    output logic DROP,
    output logic TOUT
);

    localparam logic [1:0]     ST_IDLE    = 2'd0;
    localparam logic [1:0]     ST_WAIT_HI = 2'd1;
    localparam logic [1:0]     ST_WAIT_LO = 2'd2;
    localparam logic           TO_EN      = 1'(TIMEOUT != 0);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT - 1);

    typedef struct packed {
        logic [1:0]     st;
        logic           req;
        logic           done;
        logic           drop;
        logic           tout;
        logic [TOW-1:0] cnt;
    } tmr_t;

    function automatic tmr_t vote3(tmr_t a, tmr_t b, tmr_t c);
        return tmr_t'((a & b) | (a & c) | (b & c));
    endfunction

    (* dont_touch = "true" *) logic [1:0]     st_q0, st_q1, st_q2;
    (* dont_touch = "true" *) logic           req_q0, req_q1, req_q2;
    (* dont_touch = "true" *) logic [2:0]     pls_q0, pls_q1, pls_q2;
    (* dont_touch = "true" *) logic [TOW-1:0] cnt_q0, cnt_q1, cnt_q2;

    tmr_t v;
    tmr_t nx;
    logic ack_s;
    logic timeout;

    sclib_tmr_syncff #(
        .SYNCC   (SYNCC),
        .SET1RST0(0)
    ) u_ack_sync (
        .CLK(CLK),
        .SRB(SRB),
        .D  (ACK_IN),
        .Q  (ack_s)
    );

    assign v = vote3({st_q0, req_q0, pls_q0, cnt_q0},
                     {st_q1, req_q1, pls_q1, cnt_q1},
                     {st_q2, req_q2, pls_q2, cnt_q2});

    assign timeout = TO_EN && (v.cnt == TO_LAST);

    // NOTE: every field of nx gets a default before the case, so no latch can be inferred.
    always_comb begin
        nx      = v;
        nx.done = 1'b0;
        nx.tout = 1'b0;
        nx.drop = PULSE_IN && (v.st != ST_IDLE);
        case (v.st)
            ST_IDLE: begin
                nx.req = 1'b0;
                nx.cnt = '0;
                if (PULSE_IN) begin
                    nx.st  = ST_WAIT_HI;
                    nx.req = 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (ack_s) begin
                    nx.st  = ST_WAIT_LO;
                    nx.req = 1'b0;
                    nx.cnt = '0;
                end else if (timeout) begin
                    nx.st   = ST_IDLE;
                    nx.req  = 1'b0;
                    nx.cnt  = '0;
                    nx.tout = 1'b1;
                end else begin
                    nx.cnt = v.cnt + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                // Exit condition wins over a timeout landing on the same cycle.
                if (!ack_s) begin
                    nx.st   = ST_IDLE;
                    nx.cnt  = '0;
                    nx.done = 1'b1;
                end else if (timeout) begin
                    nx.st   = ST_IDLE;
                    nx.req  = 1'b0;
                    nx.cnt  = '0;
                    nx.tout = 1'b1;
                end else begin
                    nx.cnt = v.cnt + 1'b1;
                end
            end
            default: begin
                nx.st  = ST_IDLE;
                nx.req = 1'b0;
                nx.cnt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all copies update from the same voted value.
    always_ff @(posedge CLK or negedge SRB) begin
        if (!SRB) begin
            st_q0  <= ST_IDLE;
            st_q1  <= ST_IDLE;
            st_q2  <= ST_IDLE;
            req_q0 <= 1'b0;
            req_q1 <= 1'b0;
            req_q2 <= 1'b0;
            pls_q0 <= '0;
            pls_q1 <= '0;
            pls_q2 <= '0;
            cnt_q0 <= '0;
            cnt_q1 <= '0;
            cnt_q2 <= '0;
        end else begin
            st_q0  <= nx.st;
            st_q1  <= nx.st;
            st_q2  <= nx.st;
            req_q0 <= nx.req;
            req_q1 <= nx.req;
            req_q2 <= nx.req;
            pls_q0 <= {nx.done, nx.drop, nx.tout};
            pls_q1 <= {nx.done, nx.drop, nx.tout};
            pls_q2 <= {nx.done, nx.drop, nx.tout};
            cnt_q0 <= nx.cnt;
            cnt_q1 <= nx.cnt;
            cnt_q2 <= nx.cnt;
        end
    end

    assign REQ_OUT = v.req;
    assign BUSY    = (v.st != ST_IDLE);
    assign DONE    = v.done;
    assign DROP    = v.drop;
    assign TOUT    = v.tout;

endmodule

// File: tb/tb_sclib_tmr_hs_sender.sv
// Directed bench for sclib_tmr_hs_sender: handshake, drop, timeouts, async reset, upsets, TIMEOUT=0.
// Outputs are compared as {REQ_OUT, BUSY, DONE, DROP, TOUT}.
module tb_sclib_tmr_hs_sender;

    logic clk;
    logic srb;
    logic pulse, ack;
    logic req, busy, done, drop, tout;
    logic pulse1, ack1;
    logic req1, busy1, done1, drop1, tout1;
    logic [4:0] outs, outs1;

    int n_cmp = 0;
    int n_err = 0;

    sclib_tmr_hs_sender #(.SYNCC(2), .TIMEOUT(8), .TOW(8)) u0 (
        .CLK(clk), .SRB(srb), .PULSE_IN(pulse), .ACK_IN(ack),
        .REQ_OUT(req), .BUSY(busy), .DONE(done), .DROP(drop), .TOUT(tout)
    );

    sclib_tmr_hs_sender #(.SYNCC(2), .TIMEOUT(0), .TOW(8)) u1 (
        .CLK(clk), .SRB(srb), .PULSE_IN(pulse1), .ACK_IN(ack1),
        .REQ_OUT(req1), .BUSY(busy1), .DONE(done1), .DROP(drop1), .TOUT(tout1)
    );

    assign outs  = {req, busy, done, drop, tout};
    assign outs1 = {req1, busy1, done1, drop1, tout1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the coming edge, take the edge, compare 1 ns later.
    task automatic step(input string tag, input logic p, input logic a, input logic [4:0] exp);
        pulse = p;
        ack   = a;
        @(posedge clk);
        #1;
        check(tag, 32'(outs), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       p, a;
        logic [4:0] ex;
        int         bad;

        srb = 1'b0; pulse = 1'b0; ack = 1'b0; pulse1 = 1'b0; ack1 = 1'b0;
        #2;
        check("rst_u0", 32'(outs), 32'(5'b00000));
        check("rst_u1", 32'(outs1), 32'(5'b00000));
        repeat (2) @(posedge clk);
        #1 srb = 1'b1;
        step("idle", 1'b0, 1'b0, 5'b00000);

        // Normal completion, drop on the WAIT_LO exit cycle, back-to-back accept, WAIT_HI timeout.
        for (int e = 0; e <= 21; e++) begin
            p = (e == 0 || e == 11 || e == 12);
            a = (e >= 4 && e <= 8);
            if (e <= 5)       ex = 5'b11000;
            else if (e <= 10) ex = 5'b01000;
            else if (e == 11) ex = 5'b00110;
            else if (e <= 19) ex = 5'b11000;
            else if (e == 20) ex = 5'b00001;
            else              ex = 5'b00000;
            step($sformatf("t1_e%0d", e), p, a, ex);
        end

        // Second PULSE_IN while busy is dropped; WAIT_HI times out.
        step("t2_e0", 1'b1, 1'b0, 5'b11000);
        step("t2_e1", 1'b0, 1'b0, 5'b11000);
        step("t2_e2", 1'b1, 1'b0, 5'b11010);
        for (int e = 3; e <= 7; e++) step($sformatf("t2_e%0d", e), 1'b0, 1'b0, 5'b11000);
        step("t2_e8", 1'b0, 1'b0, 5'b00001);
        step("t2_e9", 1'b0, 1'b0, 5'b00000);

        // ACK rises and stays high: WAIT_LO times out; ACK activity in IDLE is ignored.
        step("t3_e0", 1'b1, 1'b0, 5'b11000);
        step("t3_e1", 1'b0, 1'b1, 5'b11000);
        step("t3_e2", 1'b0, 1'b1, 5'b11000);
        for (int e = 3; e <= 10; e++) step($sformatf("t3_e%0d", e), 1'b0, 1'b1, 5'b01000);
        step("t3_e11", 1'b0, 1'b1, 5'b00001);
        step("t3_e12", 1'b0, 1'b1, 5'b00000);
        step("t3_e13", 1'b0, 1'b1, 5'b00000);
        for (int e = 14; e <= 16; e++) step($sformatf("t3_e%0d", e), 1'b0, 1'b0, 5'b00000);

        // Asynchronous reset in WAIT_HI, then a fresh handshake.
        step("t4_e0", 1'b1, 1'b0, 5'b11000);
        step("t4_e1", 1'b0, 1'b0, 5'b11000);
        #3 srb = 1'b0;
        #1;
        check("t4_async_rst", 32'(outs), 32'(5'b00000));
        @(posedge clk);
        #1 srb = 1'b1;
        step("t4_rel", 1'b0, 1'b0, 5'b00000);
        step("t4_n0", 1'b1, 1'b0, 5'b11000);
        step("t4_n1", 1'b0, 1'b1, 5'b11000);
        step("t4_n2", 1'b0, 1'b1, 5'b11000);
        step("t4_n3", 1'b0, 1'b1, 5'b01000);
        step("t4_n4", 1'b0, 1'b0, 5'b01000);
        step("t4_n5", 1'b0, 1'b0, 5'b01000);
        step("t4_n6", 1'b0, 1'b0, 5'b00100);
        step("t4_n7", 1'b0, 1'b0, 5'b00000);

        // Same handshake with one copy upset in each state; outputs must match the clean run.
        force u0.st_q0 = 2'd2;
        step("t5_e0", 1'b1, 1'b0, 5'b11000);
        release u0.st_q0;
        step("t5_e1", 1'b0, 1'b1, 5'b11000);
        check("t5_st_scrub", 32'(u0.st_q0), 32'(2'd1));
        force u0.cnt_q1 = 8'hAA;
        step("t5_e2", 1'b0, 1'b1, 5'b11000);
        release u0.cnt_q1;
        step("t5_e3", 1'b0, 1'b1, 5'b01000);
        check("t5_cnt_scrub", 32'(u0.cnt_q1), 32'(8'h00));
        force u0.req_q2 = 1'b1;
        step("t5_e4", 1'b0, 1'b0, 5'b01000);
        release u0.req_q2;
        step("t5_e5", 1'b0, 1'b0, 5'b01000);
        check("t5_req_scrub", 32'(u0.req_q2), 32'(1'b0));
        step("t5_e6", 1'b0, 1'b0, 5'b00100);
        step("t5_e7", 1'b0, 1'b0, 5'b00000);

        // TIMEOUT=0: REQ held for 1000 cycles with no TOUT.
        pulse1 = 1'b1;
        @(posedge clk);
        #1 pulse1 = 1'b0;
        check("t6_start", 32'(outs1), 32'(5'b11000));
        bad = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (outs1 !== 5'b11000) bad++;
        end
        check("t6_hold", 32'(bad), 32'(0));
        check("t6_u0_idle", 32'(outs), 32'(5'b00000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
